multicycle_ctrl_v2: RTL and testbench
=====================================

Name: multicycle_ctrl_v2

Overview:
Next-generation controller for the multicycle RV32I datapath. It covers the full RV32I integer/branch/jump set: R/I ALU ops including shifts and sltu, all six branches, jal, jalr, lui and auipc. It adds a memory ready handshake with a bounded-wait timeout counter. It drives the same datapath muxes as the previous controller, with ImmSrc widened to 3 bits and ALUControl widened to 4 bits.

Parameters:
TIMEOUT_W, 8, width of the memory-wait counter.
TIMEOUT_MAX, 255, wait cycles before bus_err fires; 0 disables timeout.

Ports:
clk  in  1  clock
reset  in  1  async active-high; state returns to FETCH
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero, Lt, LtU  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
mem_ready  in  1  memory completes the current access this cycle
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
AdrSrc  out  1  0 PC, 1 Result
ALUControl  out  4  ALU op code (package enum)
IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  datapath enables
bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. State goes to FETCH and wait counter to 0. bus_err is 0. All outputs are combinational from state and inputs, so after reset they show FETCH values.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, JALR, JALRLINK, BRANCH, LUI, AUIPC. A TRAP state is added when the optional feature is compiled in.
- Unlisted outputs in each state are 0. ALUOp is internal: 00 add, 01 sub, 10 funct decode.
- FETCH:
  - Outputs: A=00, B=10, ALUOp=00, ResultSrc=10, IRWrite=PCWrite=mem_ready.
  - Transition: stay until mem_ready, then go to DECODE.
- DECODE:
  - Outputs: A=01, B=01, add.
  - Transitions by op: lw/sw go to MEMADR; R goes to EXECR; I-ALU goes to EXECI; jal to JAL; jalr (1100111) to JALR; branch to BRANCH; lui (0110111) to LUI; auipc (0010111) to AUIPC; any other op goes to FETCH (no-op).
- MEMADR: A=10, B=01, add. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. Next is FETCH.
- EXECR: A=10, B=00, ALUOp=10. Next is ALUWB.
- EXECI: A=10, B=01, ALUOp=10. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
- JAL: A=01, B=10, add, ResultSrc=00, PCWrite=1. Next is ALUWB.
- JALR: A=10, B=01, add, ResultSrc=10, PCWrite=1. Next is JALRLINK.
- JALRLINK: A=01, B=10, add. Next is ALUWB.
- LUI: A=11, B=01, add. Next is ALUWB.
- AUIPC: A=01, B=01, add. Next is ALUWB.
- BRANCH: A=10, B=00, sub, ResultSrc=00. PCWrite=taken. Next is FETCH.
  - taken by funct3: 000 Zero; 001 ~Zero; 100 Lt; 101 ~Lt; 110 LtU; 111 ~LtU; 010/011 never taken.
- ImmSrc is decoded from op: sw S; branch B; jal J; lui/auipc U; all others I.
- ALU decode (ALUOp=10), by funct3:
  - 000: sub if funct7b5 & op[5], else add.
  - 001 sll; 010 slt; 011 sltu; 100 xor; 110 or; 111 and.
  - 101: sra if funct7b5, else srl.
- Wait counter:
  - Counts only in FETCH, MEMREAD and MEMWRITE while mem_ready=0. Clears on mem_ready and on any state change.
  - When count==TIMEOUT_MAX-1 with mem_ready still 0: pulse bus_err for one cycle, go to FETCH, write no enables. A FETCH timeout retries the fetch.
  - mem_ready in the same cycle as the timeout: completion wins, no bus_err.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an unknown op in DECODE goes to TRAP. TRAP holds all enables at 0, asserts extra output illegal=1, and stays until reset.
- Undefined: an unknown op goes to FETCH and the illegal port is absent.

Decomposition:
- Package mc_ctrl_pkg holds: opcodetype (extended with jalr/lui/auipc), statetype, aluctl_t, and imm-src constants.
- aluctl_t encoding: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001.
- One sub-module: mc_alu_decoder (ALUOp/funct to aluctl_t).

Test Plan:
- mem_ready=1 throughout, add (R, funct3 000, f7b5 0):
  - FETCH: IRWrite=PCWrite=1.
  - EXECR: ALUControl=0000.
  - ALUWB: RegWrite=1.
  - Back in FETCH after 4 cycles.
- lw with mem_ready low for 3 cycles in MEMREAD: AdrSrc=1 held for 4 cycles, RegWrite=0 until MEMWB, then FETCH.
- TIMEOUT_MAX=4, sw with mem_ready never asserted:
  - MemWrite=1 for 4 cycles.
  - bus_err pulses once, state returns to FETCH.
- Branches in BRANCH state:
  - bltu, LtU=1: PCWrite=1.
  - bge, Lt=1: PCWrite=0.
  - bne, Zero=0: PCWrite=1.
- jalr:
  - JALR: PCWrite=1, ResultSrc=10.
  - JALRLINK: A=01, B=10.
  - ALUWB: RegWrite=1.
  - lui: A=11, B=01, ImmSrc=100.
- Unknown op 0001111:
  - Macro undefined: FETCH after DECODE.
  - With ILLEGAL_TRAP_EN: illegal=1 and stuck in TRAP until reset; reset asserted mid-TRAP returns to FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle RV32I controller: opcodes, FSM states,
// ALU control codes, immediate-source and ALUOp constants.
// Optional build macro ILLEGAL_TRAP_EN adds the TRAP state.
package mc_ctrl_pkg;

  typedef enum logic [6:0] {
    OP_LW     = 7'b0000011,
    OP_SW     = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcodetype;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, JAL, JALR, JALRLINK, BRANCH, LUI, AUIPC
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } statetype;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } aluctl_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format depends only on the opcode, never on the state.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    case (op)
      OP_SW:            imm = IMM_S;
      OP_BRANCH:        imm = IMM_B;
      OP_JAL:           imm = IMM_J;
      OP_LUI, OP_AUIPC: imm = IMM_U;
      default:          imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5/op[5] to an ALU control code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output aluctl_t    alu_ctl
);

  // Fixed add/sub for address and PC math, funct decode for ALU instructions.
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type sub from addi, whose bit 30 is immediate data
          3'b000:  alu_ctl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctl = ALU_SLL;
          3'b010:  alu_ctl = ALU_SLT;
          3'b011:  alu_ctl = ALU_SLTU;
          3'b100:  alu_ctl = ALU_XOR;
          3'b101:  alu_ctl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctl = ALU_OR;
          default: alu_ctl = ALU_AND;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle RV32I controller with a bounded-wait memory handshake.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap and raise 'illegal'.
//
// Memory handshake: the controller presents an access (fetch, load or store)
// and holds it every cycle until mem_ready=1, which marks the access complete
// in that same cycle. If mem_ready stays low for TIMEOUT_MAX cycles, bus_err
// pulses for that last cycle and the FSM abandons the access and refetches.
module multicycle_ctrl_v2
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       LtU,
  input  logic       mem_ready,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [3:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       bus_err,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output statetype   state_dbg
);

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

  statetype             state, state_next;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [1:0]           alu_op;
  logic                 wait_state;
  logic                 timeout;
  logic                 taken;
  aluctl_t              alu_ctl;

  assign wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  // A completing access in the last wait cycle wins over the timeout.
  assign timeout    = (TIMEOUT_MAX != 0) && wait_state && !mem_ready && (wait_cnt == TO_LAST);
  assign state_dbg  = state;

  mc_alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op5      (op[5]),
    .alu_ctl  (alu_ctl)
  );
  assign ALUControl = alu_ctl;

  // Branch condition from the ALU flags of the rs1 - rs2 compare.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = ~Lt;
      3'b110:  taken = LtU;
      3'b111:  taken = ~LtU;
      default: taken = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Wait counter: runs only while an access is stalled, clears otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (!wait_state || mem_ready || timeout || (state_next != state))
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Next-state and datapath controls; every output defaults to 0 / add.
  always_comb begin
    state_next = state;
    ImmSrc     = imm_src_of(op);
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    alu_op     = ALUOP_ADD;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    bus_err    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_JAL:       state_next = JAL;
          OP_JALR:      state_next = JALR;
          OP_BRANCH:    state_next = BRANCH;
          OP_LUI:       state_next = LUI;
          OP_AUIPC:     state_next = AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next = TRAP;
`else
          default:      state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = ALUWB;
      end
      JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_next = JALRLINK;
      end
      JALRLINK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        state_next = ALUWB;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALUOP_SUB;
        PCWrite    = taken;
        state_next = FETCH;
      end
      LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        state_next = ALUWB;
      end
      AUIPC: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        state_next = ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        illegal    = 1'b1;
        state_next = TRAP;
      end
`endif
      default: state_next = FETCH;
    endcase
    // Abandoned access: no completion enables fire, fetch starts over.
    if (timeout) begin
      bus_err    = 1'b1;
      state_next = FETCH;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed bench for multicycle_ctrl_v2 (TIMEOUT_MAX=4).
module tb_multicycle_ctrl_v2;
  import mc_ctrl_pkg::*;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src;
  logic [3:0] alu_control;
  logic       ir_write, pc_write, reg_write, mem_write, bus_err;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif
  statetype   state_dbg;

  int tot = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  multicycle_ctrl_v2 #(.TIMEOUT_W(8), .TIMEOUT_MAX(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .Lt(lt), .LtU(ltu), .mem_ready(mem_ready),
    .ImmSrc(imm_src), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b),
    .ResultSrc(result_src), .AdrSrc(adr_src), .ALUControl(alu_control),
    .IRWrite(ir_write), .PCWrite(pc_write), .RegWrite(reg_write),
    .MemWrite(mem_write), .bus_err(bus_err),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .state_dbg(state_dbg)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired tot=%0d", tot);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] exp);
    check(tag, 32'(state_dbg), 32'(exp));
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // Leave FETCH idle for one cycle so the next instruction starts cleanly.
  task automatic park();
    mem_ready = 1'b0;
    to_pos();
  endtask

  // From just after an edge in FETCH: complete the fetch, stop in DECODE at negedge.
  task automatic fetch_into_decode(input string tag, input logic [2:0] exp_imm);
    mem_ready = 1'b1;
    to_neg();
    st({tag, "_fetch"}, FETCH);
    check({tag, "_irw"}, 32'(ir_write), 1);
    check({tag, "_pcw"}, 32'(pc_write), 1);
    to_pos();
    to_neg();
    st({tag, "_dec"}, DECODE);
    check({tag, "_imm"}, 32'(imm_src), 32'(exp_imm));
    check({tag, "_dec_a"}, 32'(alu_src_a), 1);
    check({tag, "_dec_b"}, 32'(alu_src_b), 1);
  endtask

  logic [6:0] a_op [10] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011,
                            7'b0010011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011};
  logic [2:0] a_f3 [10] = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b011,
                            3'b100, 3'b001, 3'b010, 3'b110, 3'b111};
  logic       a_f7 [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] a_exp[10] = '{4'd1, 4'd0, 4'd9, 4'd8, 4'd6, 4'd4, 4'd7, 4'd5, 4'd3, 4'd2};

  logic [2:0] b_f3 [6] = '{3'b110, 3'b101, 3'b001, 3'b010, 3'b000, 3'b111};
  logic       b_z  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       b_lt [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       b_ltu[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       b_exp[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int errs;
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;

    // reset state
    to_neg();
    st("rst_st", FETCH);
    check("rst_berr", 32'(bus_err), 0);
    check("rst_irw", 32'(ir_write), 0);
    check("rst_b", 32'(alu_src_b), 2);
    check("rst_res", 32'(result_src), 2);
    to_pos();
    to_pos();
    reset = 1'b0;

    // add, mem_ready high throughout, state trace through the queue
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    exp_q.push_back(FETCH); exp_q.push_back(DECODE); exp_q.push_back(EXECR);
    exp_q.push_back(ALUWB); exp_q.push_back(FETCH);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) to_pos();
      to_neg();
      st($sformatf("add_st%0d", i), exp_q.pop_front());
      if (i == 0) begin
        check("add_irw", 32'(ir_write), 1);
        check("add_pcw", 32'(pc_write), 1);
      end
      if (i == 2) begin
        check("add_ctl", 32'(alu_control), 0);
        check("add_a", 32'(alu_src_a), 2);
        check("add_b", 32'(alu_src_b), 0);
      end
      if (i == 3) check("add_rw", 32'(reg_write), 1);
    end
    park();

    // ALU decode table
    for (int i = 0; i < 10; i++) begin
      op = a_op[i]; funct3 = a_f3[i]; funct7b5 = a_f7[i];
      fetch_into_decode($sformatf("alu%0d", i), IMM_I);
      to_pos();
      to_neg();
      st($sformatf("alu%0d_ex", i), (a_op[i] == 7'b0110011) ? EXECR : EXECI);
      check($sformatf("alu%0d_ctl", i), 32'(alu_control), 32'(a_exp[i]));
      to_pos();
      to_neg();
      st($sformatf("alu%0d_wb", i), ALUWB);
      to_pos();
      to_neg();
      st($sformatf("alu%0d_end", i), FETCH);
      park();
    end
    funct7b5 = 1'b0;

    // lw with three stall cycles in MEMREAD; completion lands on the last counted cycle
    op = 7'b0000011; funct3 = 3'b010;
    fetch_into_decode("lw", IMM_I);
    to_pos();
    to_neg();
    st("lw_adr", MEMADR);
    check("lw_adr_a", 32'(alu_src_a), 2);
    check("lw_adr_b", 32'(alu_src_b), 1);
    to_pos();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      to_neg();
      st($sformatf("lw_rd%0d", i), MEMREAD);
      check($sformatf("lw_as%0d", i), 32'(adr_src), 1);
      check($sformatf("lw_rw%0d", i), 32'(reg_write), 0);
      check($sformatf("lw_be%0d", i), 32'(bus_err), 0);
      to_pos();
    end
    to_neg();
    st("lw_wb", MEMWB);
    check("lw_wb_rw", 32'(reg_write), 1);
    check("lw_wb_res", 32'(result_src), 1);
    to_pos();
    to_neg();
    st("lw_end", FETCH);
    park();

    // sw with mem_ready never asserted: timeout in MEMWRITE
    op = 7'b0100011;
    fetch_into_decode("sw", IMM_S);
    to_pos();
    to_neg();
    st("sw_adr", MEMADR);
    to_pos();
    mem_ready = 1'b0;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      st($sformatf("sw_wr%0d", i), MEMWRITE);
      check($sformatf("sw_mw%0d", i), 32'(mem_write), 1);
      check($sformatf("sw_be%0d", i), 32'(bus_err), (i == 3) ? 1 : 0);
      errs += int'(bus_err);
      to_pos();
    end
    to_neg();
    st("sw_back", FETCH);
    check("sw_be_after", 32'(bus_err), 0);
    check("sw_errs", 32'(errs), 1);

    // continuing: fetch stalls and times out, retrying in FETCH
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin
        to_pos();
        to_neg();
      end
      st($sformatf("ft_st%0d", j), FETCH);
      check($sformatf("ft_be%0d", j), 32'(bus_err), (j == 3) ? 1 : 0);
      check($sformatf("ft_irw%0d", j), 32'(ir_write), 0);
    end
    to_pos();
    to_neg();
    st("ft_retry", FETCH);
    check("ft_be_clr", 32'(bus_err), 0);
    to_pos();

    // branches
    op = 7'b1100011;
    for (int i = 0; i < 6; i++) begin
      funct3 = b_f3[i];
      fetch_into_decode($sformatf("br%0d", i), IMM_B);
      to_pos();
      zero = b_z[i]; lt = b_lt[i]; ltu = b_ltu[i];
      to_neg();
      st($sformatf("br%0d_st", i), BRANCH);
      check($sformatf("br%0d_pcw", i), 32'(pc_write), 32'(b_exp[i]));
      check($sformatf("br%0d_ctl", i), 32'(alu_control), 1);
      to_pos();
      to_neg();
      st($sformatf("br%0d_end", i), FETCH);
      park();
    end
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; funct3 = 3'b000;

    // jalr
    op = 7'b1100111;
    fetch_into_decode("jalr", IMM_I);
    to_pos();
    to_neg();
    st("jalr_st", JALR);
    check("jalr_pcw", 32'(pc_write), 1);
    check("jalr_res", 32'(result_src), 2);
    to_pos();
    to_neg();
    st("jalr_link", JALRLINK);
    check("jalr_link_a", 32'(alu_src_a), 1);
    check("jalr_link_b", 32'(alu_src_b), 2);
    check("jalr_link_pcw", 32'(pc_write), 0);
    to_pos();
    to_neg();
    st("jalr_wb", ALUWB);
    check("jalr_wb_rw", 32'(reg_write), 1);
    to_pos();
    to_neg();
    st("jalr_end", FETCH);
    park();

    // jal
    op = 7'b1101111;
    fetch_into_decode("jal", IMM_J);
    to_pos();
    to_neg();
    st("jal_st", JAL);
    check("jal_pcw", 32'(pc_write), 1);
    check("jal_a", 32'(alu_src_a), 1);
    check("jal_b", 32'(alu_src_b), 2);
    to_pos();
    to_neg();
    st("jal_wb", ALUWB);
    to_pos();
    park();

    // lui
    op = 7'b0110111;
    fetch_into_decode("lui", IMM_U);
    to_pos();
    to_neg();
    st("lui_st", LUI);
    check("lui_a", 32'(alu_src_a), 3);
    check("lui_b", 32'(alu_src_b), 1);
    check("lui_imm", 32'(imm_src), 4);
    to_pos();
    to_neg();
    st("lui_wb", ALUWB);
    to_pos();
    park();

    // auipc
    op = 7'b0010111;
    fetch_into_decode("auipc", IMM_U);
    to_pos();
    to_neg();
    st("auipc_st", AUIPC);
    check("auipc_a", 32'(alu_src_a), 1);
    check("auipc_b", 32'(alu_src_b), 1);
    to_pos();
    to_neg();
    st("auipc_wb", ALUWB);
    to_pos();
    park();

    // unknown opcode
    op = 7'b0001111;
    fetch_into_decode("unk", IMM_I);
    check("unk_dec_rw", 32'(reg_write), 0);
    to_pos();
    to_neg();
`ifdef ILLEGAL_TRAP_EN
    st("unk_trap", TRAP);
    check("unk_ill", 32'(illegal), 1);
    for (int i = 0; i < 3; i++) begin
      to_pos();
      to_neg();
      st($sformatf("unk_hold%0d", i), TRAP);
      check($sformatf("unk_irw%0d", i), 32'(ir_write), 0);
      check($sformatf("unk_pcw%0d", i), 32'(pc_write), 0);
    end
    reset = 1'b1;
    #1;
    st("unk_rst", FETCH);
    check("unk_ill_clr", 32'(illegal), 0);
    to_pos();
    reset = 1'b0;
    mem_ready = 1'b0;
    to_neg();
    st("unk_after", FETCH);
`else
    st("unk_skip", FETCH);
    check("unk_pcw", 32'(pc_write), 1);
`endif

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
